// File: rtl/axi_chan_fifo.sv
// Single-clock valid/ready FIFO for AXI channel beats with occupancy, almost-full and high-water telemetry.
// Define AXI_FIFO_BYPASS_EN for a zero-cycle cut-through path when the FIFO is empty.
module axi_chan_fifo #(
  parameter int DATA_W   = 45,
  parameter int DEPTH    = 4,
  parameter int AFULL_TH = DEPTH - 1,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W:0]   count,
  output logic              almost_full,
  output logic [ADDR_W:0]   high_water
);

  localparam logic [ADDR_W:0] AFULL_TH_C = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] PTR_ZERO   = {(ADDR_W+1){1'b0}};

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W:0]   wptr_q, wptr_d;
  logic [ADDR_W:0]   rptr_q, rptr_d;
  logic [ADDR_W:0]   hw_q, hw_d;
  logic [ADDR_W:0]   count_d;
  logic              empty_s, full_s, push_s, pop_s, bypass_s;

  // Status flags and handshake outputs derived from the registered pointers.
  always_comb begin
    empty_s     = (wptr_q == rptr_q);
    full_s      = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
                  (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);
    count       = wptr_q - rptr_q;
    almost_full = (count >= AFULL_TH_C);
    s_ready     = !full_s;
    high_water  = hw_q;
`ifdef AXI_FIFO_BYPASS_EN
    // An empty FIFO presents the upstream beat directly; if taken it is never stored.
    bypass_s    = empty_s && s_valid && m_ready;
    m_valid     = empty_s ? s_valid : 1'b1;
    m_data      = empty_s ? s_data : mem_q[rptr_q[ADDR_W-1:0]];
`else
    bypass_s    = 1'b0;
    m_valid     = !empty_s;
    m_data      = mem_q[rptr_q[ADDR_W-1:0]];
`endif
    push_s      = s_valid && s_ready && !bypass_s;
    pop_s       = !empty_s && m_ready;
  end

  // Next-state pointers and high-water mark; flush overrides any handshake.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    hw_d    = hw_q;
    count_d = PTR_ZERO;
    if (flush) begin
      wptr_d = PTR_ZERO;
      rptr_d = PTR_ZERO;
      hw_d   = PTR_ZERO;
    end else begin
      wptr_d  = wptr_q + {{ADDR_W{1'b0}}, push_s};
      rptr_d  = rptr_q + {{ADDR_W{1'b0}}, pop_s};
      count_d = wptr_d - rptr_d;
      if (count_d > hw_q) begin
        hw_d = count_d;
      end else begin
        hw_d = hw_q;
      end
    end
  end

  // Pointer and telemetry registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= PTR_ZERO;
      rptr_q <= PTR_ZERO;
      hw_q   <= PTR_ZERO;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      hw_q   <= hw_d;
    end
  end

  // Payload storage; intentionally not reset, and left untouched by flush.
  always_ff @(posedge clk) begin
    if (push_s && !flush) begin
      mem_q[wptr_q[ADDR_W-1:0]] <= s_data;
    end
  end

endmodule

// File: tb/tb_axi_chan_fifo.sv
// Directed scoreboard bench for axi_chan_fifo (DATA_W=8, DEPTH=4, AFULL_TH=3).
module tb_axi_chan_fifo;

`ifdef AXI_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, flush, s_valid, s_ready, m_valid, m_ready, almost_full;
  logic [7:0] s_data, m_data;
  logic [2:0] count, high_water;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  axi_chan_fifo #(.DATA_W(8), .DEPTH(4), .AFULL_TH(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .count(count), .almost_full(almost_full), .high_water(high_water)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted head beat must match the scoreboard head.
  always @(negedge clk) begin
    if (rst && m_valid && m_ready && !flush) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got %0h expected none", m_data);
      end else begin
        chk("beat_order", {24'h0, m_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    logic [7:0] v;
    rst = 1'b0; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = 8'h00;
    #12;
    chk("rst_s_ready", {31'h0, s_ready}, 32'd1);
    chk("rst_m_valid", {31'h0, m_valid}, 32'd0);
    chk("rst_count", {29'h0, count}, 32'd0);
    chk("rst_afull", {31'h0, almost_full}, 32'd0);
    chk("rst_hw", {29'h0, high_water}, 32'd0);
    tick();
    rst = 1'b1;

    // Fill with m_ready low.
    for (int i = 0; i < 4; i++) begin
      v = 8'h11 * 8'(i + 1);
      exp_q.push_back(v);
      s_valid = 1'b1; s_data = v;
      tick();
      chk("fill_count", {29'h0, count}, 32'(i + 1));
      chk("fill_afull", {31'h0, almost_full}, (i + 1 >= 3) ? 32'd1 : 32'd0);
      chk("fill_s_ready", {31'h0, s_ready}, (i + 1 < 4) ? 32'd1 : 32'd0);
      chk("fill_head", {24'h0, m_data}, 32'h11);
    end
    chk("fill_hw", {29'h0, high_water}, 32'd4);

    // Full: pop once while 0x55 is held; it must wait one cycle.
    s_valid = 1'b1; s_data = 8'h55; m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("full_pop_count", {29'h0, count}, 32'd3);
    chk("full_pop_s_ready", {31'h0, s_ready}, 32'd1);
    exp_q.push_back(8'h55);
    tick();
    s_valid = 1'b0;
    chk("refill_count", {29'h0, count}, 32'd4);
    m_ready = 1'b1;
    repeat (4) tick();
    m_ready = 1'b0;
    chk("drain_count", {29'h0, count}, 32'd0);
    chk("drain_m_valid", {31'h0, m_valid}, 32'd0);
    chk("drain_hw", {29'h0, high_water}, 32'd4);

    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_hw_clear", {29'h0, high_water}, 32'd0);

    // Streaming push/pop across several pointer wraps.
    s_valid = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(8'(i));
      s_data = 8'(i);
      tick();
      chk("stream_count", {29'h0, count}, BYP ? 32'd0 : 32'd1);
    end
    s_valid = 1'b0;
    tick();
    m_ready = 1'b0;
    chk("stream_end_count", {29'h0, count}, 32'd0);
    chk("stream_hw", {29'h0, high_water}, BYP ? 32'd0 : 32'd1);

    // Fill to 3 then flush with both handshakes high.
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = 8'h61 + 8'(i);
      exp_q.push_back(s_data);
      tick();
    end
    chk("pre_flush_count", {29'h0, count}, 32'd3);
    flush = 1'b1; s_valid = 1'b1; s_data = 8'h64; m_ready = 1'b1;
    tick();
    flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    exp_q.delete();
    chk("flush_count", {29'h0, count}, 32'd0);
    chk("flush_m_valid", {31'h0, m_valid}, 32'd0);
    chk("flush_hw", {29'h0, high_water}, 32'd0);
    s_valid = 1'b1; s_data = 8'h70;
    exp_q.push_back(8'h70);
    tick();
    s_valid = 1'b0;
    chk("post_flush_head", {24'h0, m_data}, 32'h70);
    chk("post_flush_count", {29'h0, count}, 32'd1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;

    // Asynchronous reset mid-stream at count 2.
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1; s_data = 8'h81 + 8'(i);
      exp_q.push_back(s_data);
      tick();
    end
    s_valid = 1'b0;
    chk("pre_rst_count", {29'h0, count}, 32'd2);
    rst = 1'b0;
    #1;
    chk("arst_s_ready", {31'h0, s_ready}, 32'd1);
    chk("arst_m_valid", {31'h0, m_valid}, 32'd0);
    chk("arst_count", {29'h0, count}, 32'd0);
    chk("arst_hw", {29'h0, high_water}, 32'd0);
    exp_q.delete();
    tick();
    rst = 1'b1;

    // Latency from empty: cut-through with the option, one cycle without.
    exp_q.push_back(8'hA5);
    s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b1;
    #1;
    chk("lat0_m_valid", {31'h0, m_valid}, BYP ? 32'd1 : 32'd0);
    chk("lat0_count", {29'h0, count}, 32'd0);
    if (BYP) chk("lat0_m_data", {24'h0, m_data}, 32'hA5);
    tick();
    s_valid = 1'b0;
    chk("lat1_m_valid", {31'h0, m_valid}, BYP ? 32'd0 : 32'd1);
    chk("lat1_count", {29'h0, count}, BYP ? 32'd0 : 32'd1);
    tick();
    m_ready = 1'b0;
    chk("lat2_count", {29'h0, count}, 32'd0);
    chk("lat2_m_valid", {31'h0, m_valid}, 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
